// File: rtl/pc_ir_unit_pkg.sv
// Shared definitions for the PC / IR / memory-interface stage.
//  - default datapath width and reset PC
//  - memory access FSM state encoding
//  - access-kind codes carried through a multi-cycle access
package pc_ir_unit_pkg;

  localparam int          XLEN_DEF     = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  // Memory access FSM states
  localparam logic [0:0] MEM_IDLE = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  // Kind of access in flight; decides which register commits on completion
  localparam logic [1:0] ACC_FETCH = 2'd0;
  localparam logic [1:0] ACC_LOAD  = 2'd1;
  localparam logic [1:0] ACC_STORE = 2'd2;

endpackage

// File: rtl/pc_ir_unit_mem_access_fsm.sv
// Memory access sequencer for the unified instruction/data port.
// IDLE issues the request straight from the control inputs; if memory is
// not ready the address/we/wdata/kind are latched and WAIT holds them until
// mem_ready or until the timeout counter expires.
// Ports:
//  clk, rst_n            clock, async active-low reset
//  req_i, we_i           access request / write enable from decode
//  kind_i                ACC_FETCH / ACC_LOAD / ACC_STORE
//  addr_i, wdata_i       address (bit0 already cleared) and store data
//  mem_ready_i           memory completes this cycle
//  mem_req_o .. wdata_o  memory port drive
//  kind_o                kind of the access currently presented
//  stall_o               access presented but not completing this cycle
//  done_o                access completes this cycle
//  timeout_o             access abandoned this cycle
//  idle_o                FSM in IDLE (inputs are live, not latched)
module mem_access_fsm
  import pc_ir_unit_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [1:0]      kind_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            mem_ready_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [1:0]      kind_o,
  output logic            stall_o,
  output logic            done_o,
  output logic            timeout_o,
  output logic            idle_o
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  logic [0:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, wd_q;
  logic            we_q;
  logic [1:0]      kind_q;
  logic            in_wait;

  assign in_wait = (state_q == MEM_WAIT);
  assign idle_o  = ~in_wait;

  // Request is gated by reset so the port drops the instant reset asserts,
  // even though the control inputs may still be requesting.
  assign mem_req_o   = rst_n & (in_wait | req_i);
  assign mem_we_o    = in_wait ? we_q   : we_i;
  assign mem_addr_o  = in_wait ? addr_q : addr_i;
  assign mem_wdata_o = in_wait ? wd_q   : wdata_i;
  assign kind_o      = in_wait ? kind_q : kind_i;
  assign stall_o     = mem_req_o & ~mem_ready_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_o    = 1'b0;
    timeout_o = 1'b0;
    if (!in_wait) begin
      if (req_i) begin
        if (mem_ready_i) begin
          done_o = 1'b1;
        end else begin
          state_d = MEM_WAIT;
          cnt_d   = 8'd1;
        end
      end
    end else begin
      if (mem_ready_i) begin
        done_o  = 1'b1;
        state_d = MEM_IDLE;
        cnt_d   = 8'd0;
      end else if (cnt_q == TO_CNT) begin
        timeout_o = 1'b1;
        state_d   = MEM_IDLE;
        cnt_d     = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      kind_q  <= ACC_FETCH;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Shadow the live request while idle; frozen once WAIT is entered
      if (!in_wait) begin
        addr_q <= addr_i;
        wd_q   <= wdata_i;
        we_q   <= we_i;
        kind_q <= kind_i;
      end
    end
  end

endmodule

// File: rtl/pc_ir_unit.sv
// PC / OldPC / IR / data register stage feeding the multicycle control unit.
// Executes pc_write/adr_src/ir_wr/mem_wr, drives the unified memory port
// and stalls while an access is outstanding.
// Ports:
//  clk, rst_n                    clock, async active-low reset
//  pc_write, adr_src, ir_wr,
//  mem_wr                        control from the control unit
//  result, wd                    result bus (next PC / address), store data
//  mem_rdata, mem_ready          memory response
//  mem_req, mem_we, mem_addr,
//  mem_wdata                     memory request
//  instr, pc, old_pc, data       architectural registers
//  stall                         access not completing this cycle
//  bus_err, misalign             sticky fault flags
module pc_ir_unit
  import pc_ir_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            adr_src,
  input  logic            ir_wr,
  input  logic            mem_wr,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] wd,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic [XLEN-1:0] data,
  output logic            stall,
  output logic            bus_err,
  output logic            misalign
);

  logic [XLEN-1:0] pc_q, old_pc_q, instr_q, data_q;
  logic            bus_err_q, misalign_q;

  logic            rd, wr, req, conflict;
  logic [1:0]      kind_in, kind;
  logic [XLEN-1:0] raw_addr, acc_addr;
  logic            done, timeout, idle, pc_load;

  // A store wins over a simultaneous fetch; the conflict is flagged.
  assign conflict = ir_wr & mem_wr;
  assign rd       = ir_wr | (adr_src & ~mem_wr);
  assign wr       = mem_wr;
  assign req      = rd | wr;
  assign kind_in  = wr ? ACC_STORE : (ir_wr ? ACC_FETCH : ACC_LOAD);

  assign raw_addr = adr_src ? result : pc_q;
  assign acc_addr = {raw_addr[XLEN-1:1], 1'b0};

  mem_access_fsm #(
    .XLEN    (XLEN),
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .we_i        (wr),
    .kind_i      (kind_in),
    .addr_i      (acc_addr),
    .wdata_i     (wd),
    .mem_ready_i (mem_ready),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .kind_o      (kind),
    .stall_o     (stall),
    .done_o      (done),
    .timeout_o   (timeout),
    .idle_o      (idle)
  );

  // PC only moves in a non-stalled cycle, so a fetch's pc+2 lands together
  // with the IR load, and a timed-out access commits nothing.
  assign pc_load = pc_write & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      old_pc_q   <= '0;
      instr_q    <= '0;
      data_q     <= '0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      if (done && kind == ACC_FETCH) begin
        instr_q  <= mem_rdata;
        old_pc_q <= pc_q;     // pre-update PC even if pc_load fires now
      end
      if (done && kind == ACC_LOAD)
        data_q <= mem_rdata;
      if (pc_load)
        pc_q <= {result[XLEN-1:1], 1'b0};
      // Access address is only inspected when issued from IDLE; in WAIT
      // the latched, already-aligned address is in use.
      if ((pc_load && result[0]) || (idle && req && raw_addr[0]))
        misalign_q <= 1'b1;
      if (timeout || (idle && conflict))
        bus_err_q <= 1'b1;
    end
  end

  assign pc       = pc_q;
  assign old_pc   = old_pc_q;
  assign instr    = instr_q;
  assign data     = data_q;
  assign bus_err  = bus_err_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
module tb_pc_ir_unit;

  logic        clk, rst_n;
  logic        pc_write, adr_src, ir_wr, mem_wr, mem_ready;
  logic [15:0] result, wd, mem_rdata;
  logic        mem_req, mem_we, stall, bus_err, misalign;
  logic [15:0] mem_addr, mem_wdata, instr, pc, old_pc, data;

  int checks = 0;
  int errors = 0;

  pc_ir_unit #(.XLEN(16), .RESET_PC(16'h0000), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_write(pc_write), .adr_src(adr_src), .ir_wr(ir_wr), .mem_wr(mem_wr),
    .result(result), .wd(wd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .instr(instr), .pc(pc), .old_pc(old_pc), .data(data),
    .stall(stall), .bus_err(bus_err), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pw, as, ir, mw;
    logic [15:0] res, wdat, rdata;
    logic        rdy;
    // expected combinational port values this cycle
    logic        e_req, e_we;
    logic [15:0] e_addr, e_wdata;
    logic        e_stall;
    // expected register values after the edge
    logic [15:0] e_pc, e_instr, e_old, e_data;
    logic        e_be, e_mis;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic as, input logic ir, input logic mw,
                       input logic [15:0] res, input logic [15:0] wdat,
                       input logic [15:0] rdata, input logic rdy);
    pc_write = pw; adr_src = as; ir_wr = ir; mem_wr = mw;
    result = res; wd = wdat; mem_rdata = rdata; mem_ready = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int i);
    @(negedge clk);
    drive(v.pw, v.as, v.ir, v.mw, v.res, v.wdat, v.rdata, v.rdy);
    #1;
    chk($sformatf("v%0d.mem_req", i), 16'(mem_req), 16'(v.e_req));
    chk($sformatf("v%0d.stall", i), 16'(stall), 16'(v.e_stall));
    if (v.e_req) begin
      chk($sformatf("v%0d.mem_we", i), 16'(mem_we), 16'(v.e_we));
      chk($sformatf("v%0d.mem_addr", i), mem_addr, v.e_addr);
      chk($sformatf("v%0d.mem_wdata", i), mem_wdata, v.e_wdata);
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d.pc", i), pc, v.e_pc);
    chk($sformatf("v%0d.instr", i), instr, v.e_instr);
    chk($sformatf("v%0d.old_pc", i), old_pc, v.e_old);
    chk($sformatf("v%0d.data", i), data, v.e_data);
    chk($sformatf("v%0d.bus_err", i), 16'(bus_err), 16'(v.e_be));
    chk($sformatf("v%0d.misalign", i), 16'(misalign), 16'(v.e_mis));
  endtask

  initial begin
    //          pw as ir mw  res       wd        rdata     rdy  req we addr      wdata     stl  pc        instr     old       data      be mis
    // zero-wait fetch, pc -> 2
    tbl[0]  = '{1, 0, 1, 0, 16'h0002, 16'h0000, 16'h1234, 1,   1, 0, 16'h0000, 16'h0000, 0,   16'h0002, 16'h1234, 16'h0000, 16'h0000, 0, 0};
    // fetch with three wait states; inputs disturbed mid-WAIT are ignored
    tbl[1]  = '{1, 0, 1, 0, 16'h0004, 16'h0000, 16'hDEAD, 0,   1, 0, 16'h0002, 16'h0000, 1,   16'h0002, 16'h1234, 16'h0000, 16'h0000, 0, 0};
    tbl[2]  = '{1, 1, 1, 1, 16'h0004, 16'h5555, 16'hDEAD, 0,   1, 0, 16'h0002, 16'h0000, 1,   16'h0002, 16'h1234, 16'h0000, 16'h0000, 0, 0};
    tbl[3]  = '{1, 0, 1, 0, 16'h0004, 16'h0000, 16'hDEAD, 0,   1, 0, 16'h0002, 16'h0000, 1,   16'h0002, 16'h1234, 16'h0000, 16'h0000, 0, 0};
    tbl[4]  = '{1, 0, 1, 0, 16'h0004, 16'h0000, 16'hABCD, 1,   1, 0, 16'h0002, 16'h0000, 0,   16'h0004, 16'hABCD, 16'h0002, 16'h0000, 0, 0};
    // load / store at 0x0040
    tbl[5]  = '{0, 1, 0, 0, 16'h0040, 16'h0000, 16'hBEEF, 1,   1, 0, 16'h0040, 16'h0000, 0,   16'h0004, 16'hABCD, 16'h0002, 16'hBEEF, 0, 0};
    tbl[6]  = '{0, 1, 0, 1, 16'h0040, 16'h00AA, 16'h0000, 1,   1, 1, 16'h0040, 16'h00AA, 0,   16'h0004, 16'hABCD, 16'h0002, 16'hBEEF, 0, 0};
    // no request
    tbl[7]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0,   0, 0, 16'h0004, 16'h0000, 0,   16'h0004, 16'hABCD, 16'h0002, 16'hBEEF, 0, 0};
    // load with one wait state; result change during WAIT is ignored
    tbl[8]  = '{0, 1, 0, 0, 16'h0050, 16'h0000, 16'h0000, 0,   1, 0, 16'h0050, 16'h0000, 1,   16'h0004, 16'hABCD, 16'h0002, 16'hBEEF, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 16'h0060, 16'h0000, 16'h7777, 1,   1, 0, 16'h0050, 16'h0000, 0,   16'h0004, 16'hABCD, 16'h0002, 16'h7777, 0, 0};
    // odd pc_write target
    tbl[10] = '{1, 0, 0, 0, 16'h0103, 16'h0000, 16'h0000, 0,   0, 0, 16'h0004, 16'h0000, 0,   16'h0102, 16'hABCD, 16'h0002, 16'h7777, 0, 1};
    // ir_wr & mem_wr: store at pc, IR untouched, bus_err
    tbl[11] = '{0, 0, 1, 1, 16'h0000, 16'h0033, 16'h9999, 1,   1, 1, 16'h0102, 16'h0033, 0,   16'h0102, 16'hABCD, 16'h0002, 16'h7777, 1, 1};
    // PC wrap: fetch at 0xFFFE commits pc = 0x0000
    tbl[12] = '{1, 0, 0, 0, 16'hFFFE, 16'h0000, 16'h0000, 0,   0, 0, 16'h0102, 16'h0000, 0,   16'hFFFE, 16'hABCD, 16'h0002, 16'h7777, 1, 1};
    tbl[13] = '{1, 0, 1, 0, 16'h0000, 16'h0000, 16'h4321, 1,   1, 0, 16'hFFFE, 16'h0000, 0,   16'h0000, 16'h4321, 16'hFFFE, 16'h7777, 1, 1};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst.pc", pc, 16'h0000);
    chk("rst.instr", instr, 16'h0000);
    chk("rst.old_pc", old_pc, 16'h0000);
    chk("rst.data", data, 16'h0000);
    chk("rst.bus_err", 16'(bus_err), 16'h0000);
    chk("rst.misalign", 16'(misalign), 16'h0000);
    chk("rst.mem_req", 16'(mem_req), 16'h0000);
    chk("rst.stall", 16'(stall), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Timeout: fetch at 0 never acknowledged; 4 WAIT cycles then abandon
    @(negedge clk);
    drive(1, 0, 1, 0, 16'h0002, 16'h0, 16'hFFFF, 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("to.bus_err%0d", k), 16'(bus_err), (k == 5) ? 16'h0001 : 16'h0000);
      if (k < 5) chk($sformatf("to.addr%0d", k), mem_addr, 16'h0000);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0);
    #1;
    chk("to.idle_req", 16'(mem_req), 16'h0000);
    chk("to.instr", instr, 16'h0000);
    chk("to.pc", pc, 16'h0000);

    // Reset in the middle of a waited fetch
    @(negedge clk);
    drive(1, 0, 0, 0, 16'h0020, 16'h0, 16'h0, 0);
    @(negedge clk);
    drive(1, 0, 1, 0, 16'h0022, 16'h0, 16'h5A5A, 0);
    @(posedge clk);
    #2;
    chk("mr.req_before", 16'(mem_req), 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("mr.mem_req", 16'(mem_req), 16'h0000);
    chk("mr.stall", 16'(stall), 16'h0000);
    @(negedge clk);
    drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0);
    rst_n = 1'b1;
    #1;
    chk("mr.pc", pc, 16'h0000);
    chk("mr.instr", instr, 16'h0000);
    chk("mr.bus_err", 16'(bus_err), 16'h0000);

    // Odd data address: aligned on the port, flagged, access completes
    @(negedge clk);
    drive(0, 1, 0, 0, 16'h0041, 16'h0, 16'h1111, 1);
    #1;
    chk("odd.addr", mem_addr, 16'h0040);
    @(posedge clk);
    #1;
    chk("odd.misalign", 16'(misalign), 16'h0001);
    chk("odd.data", data, 16'h1111);

    do_reset();
    for (int i = 0; i < 14; i++) apply(tbl[i], i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
